// File: rtl/act_stream_seq.sv
// rtl/act_stream_seq.sv - int8 activation burst sequencer with shared activation units
//
// act_stream_seq: accepts a command (function, burst length), then streams
// cmd_len int8 elements from in_* to out_* through one registered stage,
// applying the selected activation. done pulses for one cycle after the burst.
//   clk, rst_n                         clock, async active-low reset
//   cmd_valid/cmd_ready/cmd_func/cmd_len  command handshake
//   in_valid/in_ready/in_data          input element stream
//   out_valid/out_ready/out_data/out_last result stream
//   busy, done                         status
//
// Activation units (combinational, int8 in / int8 out):
//   relu_int8       max(x, 0)
//   relu6_int8      min(max(x, 0), 6)
//   leakyrelu_int8  x >= 0 ? x : floor(x / 4)
//   tanh_int8       hard-tanh: clamp(4x, -127, 127)
//   gelu_int8       x <= 0 ? 0 : (x < 16 ? floor(x*x/16) : x)

module relu_int8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = a[7] ? 8'd0 : a;
endmodule

module relu6_int8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Non-negative values compare correctly as unsigned.
  assign y = a[7] ? 8'd0 : ((a > 8'd6) ? 8'd6 : a);
endmodule

module leakyrelu_int8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  // Arithmetic shift right by 2 gives floor(x/4) for negative x.
  assign y = a[7] ? {a[7], a[7], a[7:2]} : a;
endmodule

module tanh_int8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic signed [7:0] s;
  assign s = a;
  // Inside [-31, 31] the 4x slope still fits in int8; outside it saturates
  // symmetrically to +/-127.
  assign y = (s > 8'sd31)  ? 8'h7f :
             (s < -8'sd31) ? 8'h81 :
             {a[5:0], 2'b00};
endmodule

module gelu_int8 (
  input  logic [7:0] a,
  output logic [7:0] y
);
  logic [7:0] sq;
  // Quadratic knee below 16 meets the identity line exactly at x = 16.
  assign sq = {4'd0, a[3:0]} * {4'd0, a[3:0]};
  assign y  = (a[7] || (a == 8'd0)) ? 8'd0 :
              (a < 8'd16)           ? {4'd0, sq[7:4]} :
              a;
endmodule

module act_stream_seq #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_func,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t           state, state_nxt;
  logic [2:0]       func_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] in_cnt;
  logic [LEN_W-1:0] out_cnt;

  logic [7:0] y_relu, y_relu6, y_leaky, y_tanh, y_gelu, act_y;
  logic       in_hs, out_hs, cmd_hs;

  relu_int8      u_relu  (.a(in_data), .y(y_relu));
  relu6_int8     u_relu6 (.a(in_data), .y(y_relu6));
  leakyrelu_int8 u_leaky (.a(in_data), .y(y_leaky));
  tanh_int8      u_tanh  (.a(in_data), .y(y_tanh));
  gelu_int8      u_gelu  (.a(in_data), .y(y_gelu));

  always_comb begin
    act_y = in_data;
    case (func_q)
      3'd0:    act_y = y_relu;
      3'd1:    act_y = y_relu6;
      3'd2:    act_y = y_leaky;
      3'd3:    act_y = y_tanh;
      3'd4:    act_y = y_gelu;
      default: act_y = in_data;
    endcase
  end

  assign cmd_hs = cmd_valid && cmd_ready;
  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = (cmd_len == '0) ? FIN : RUN;
      end
      RUN: begin
        busy     = 1'b1;
        // A new element may enter only if the output register is free or
        // being drained this cycle.
        in_ready = (in_cnt < len_q) && (!out_valid || out_ready);
        if (out_hs && out_last) state_nxt = FIN;
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      func_q    <= 3'd0;
      len_q     <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      out_last  <= 1'b0;
    end else begin
      if (cmd_hs) begin
        func_q  <= cmd_func;
        len_q   <= cmd_len;
        in_cnt  <= '0;
        out_cnt <= '0;
      end
      if (in_hs) begin
        out_data  <= act_y;
        out_valid <= 1'b1;
        out_last  <= (in_cnt == len_q - LEN_ONE);
        in_cnt    <= in_cnt + LEN_ONE;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
      if (out_hs) out_cnt <= out_cnt + LEN_ONE;
    end
  end
endmodule

// File: tb/tb_act_stream_seq.sv
// tb/tb_act_stream_seq.sv - self-checking bench for act_stream_seq against a transaction model
module tb_act_stream_seq;
  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_func;
  logic [LW-1:0] cmd_len;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  act_stream_seq #(.LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_func(cmd_func), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  // Transaction-level model of the burst.
  bit m_active, m_fin, m_has_out, m_out_last;
  int m_func, m_in_left, m_out_left, m_out_val;

  int obs_q[$];
  int obs_last_cnt;
  int done_cnt;
  int outv_cnt;

  function automatic int act(input int f, input int x);
    int t;
    t = 4 * x;
    case (f)
      0:       return (x < 0) ? 0 : x;
      1:       return (x < 0) ? 0 : ((x > 6) ? 6 : x);
      2:       return (x >= 0) ? x : (x - 3) / 4;
      3:       return (t > 127) ? 127 : ((t < -127) ? -127 : t);
      4:       return (x <= 0) ? 0 : ((x < 16) ? (x * x) / 16 : x);
      default: return x;
    endcase
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s actual=%0d expected=%0d", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_has_out = 0; m_out_last = 0;
    m_func = 0; m_in_left = 0; m_out_left = 0; m_out_val = 0;
  endtask

  task automatic obs_clear();
    obs_q.delete();
    obs_last_cnt = 0;
  endtask

  task automatic chk_obs(input string nm, input int n, input int e0, input int e1,
                         input int e2, input int e3);
    int e[4];
    e = '{e0, e1, e2, e3};
    chk({nm, "_count"}, obs_q.size(), n);
    for (int i = 0; i < n && i < obs_q.size(); i++) chk(nm, obs_q[i], e[i]);
    chk({nm, "_last_count"}, obs_last_cnt, 1);
  endtask

  // One clock cycle: drive, compare against model, advance model, cross the edge.
  task automatic step(input logic cv, input int cf, input int cl, input logic iv,
                      input int id, input logic ordy);
    bit exp_in_ready, in_hs, out_hs;
    int x;
    cmd_valid = cv; cmd_func = 3'(cf); cmd_len = LW'(cl);
    in_valid = iv; in_data = 8'(id); out_ready = ordy;
    #1;
    exp_in_ready = m_active && (m_in_left > 0) && (!m_has_out || ordy);
    chk("cmd_ready", int'(cmd_ready), int'(!m_active && !m_fin));
    chk("busy", int'(busy), int'(m_active));
    chk("done", int'(done), int'(m_fin));
    chk("in_ready", int'(in_ready), int'(exp_in_ready));
    chk("out_valid", int'(out_valid), int'(m_has_out));
    if (m_has_out) begin
      chk("out_data", int'($signed(out_data)), m_out_val);
      chk("out_last", int'(out_last), int'(m_out_last));
    end
    if (out_valid && ordy) begin
      obs_q.push_back(int'($signed(out_data)));
      if (out_last) obs_last_cnt++;
    end
    if (done) done_cnt++;
    if (out_valid) outv_cnt++;

    if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (cv) begin
        m_func = cf;
        if (cl == 0) m_fin = 1;
        else begin
          m_active = 1; m_in_left = cl; m_out_left = cl; m_has_out = 0;
        end
      end
    end else begin
      out_hs = m_has_out && ordy;
      in_hs  = exp_in_ready && iv;
      if (out_hs) begin
        m_out_left--;
        if (m_out_left == 0) begin m_active = 0; m_fin = 1; end
      end
      if (in_hs) begin
        x = int'($signed(8'(id)));
        m_has_out = 1; m_out_val = act(m_func, x);
        m_out_last = (m_in_left == 1); m_in_left--;
      end else if (out_hs) begin
        m_has_out = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1);
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({nm, "_in_ready"}, int'(in_ready), 0);
    chk({nm, "_out_valid"}, int'(out_valid), 0);
    chk({nm, "_out_data"}, int'(out_data), 0);
    chk({nm, "_out_last"}, int'(out_last), 0);
    chk({nm, "_busy"}, int'(busy), 0);
    chk({nm, "_done"}, int'(done), 0);
  endtask

  initial begin
    int d0, v0, guard;
    rst_n = 0; cmd_valid = 0; cmd_func = 0; cmd_len = 0;
    in_valid = 0; in_data = 0; out_ready = 1;
    done_cnt = 0; outv_cnt = 0;
    model_reset(); obs_clear();

    // Pin the reference functions with hand-computed values.
    chk("act_relu_neg", act(0, -128), 0);
    chk("act_leaky_m8", act(2, -8), -2);
    chk("act_leaky_m3", act(2, -3), -1);
    chk("act_tanh_50", act(3, 50), 127);
    chk("act_tanh_m50", act(3, -50), -127);
    chk("act_relu6_7", act(1, 7), 6);
    chk("act_gelu_8", act(4, 8), 4);
    chk("act_gelu_m8", act(4, -8), 0);
    chk("act_ident", act(6, -100), -100);

    #12;
    chk_reset_outputs("reset");
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;

    // 1. relu burst at full throughput.
    step(1, 0, 4, 0, 0, 1); obs_clear();
    step(0, 0, 0, 1, 5, 1);
    step(0, 0, 0, 1, -3, 1);
    step(0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 1, -128, 1);
    idle(3);
    chk_obs("t1_relu", 4, 5, 0, 0, 0);

    // 2. leaky with a 3-cycle stall on the first result.
    step(1, 2, 2, 0, 0, 1); obs_clear();
    step(0, 0, 0, 1, -8, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 8, 0);
    step(0, 0, 0, 1, 8, 1);
    idle(3);
    chk_obs("t2_leaky", 2, -2, 8, 0, 0);

    // 3. tanh then relu6.
    step(1, 3, 2, 0, 0, 1); obs_clear();
    step(0, 0, 0, 1, 50, 1);
    step(0, 0, 0, 1, -50, 1);
    idle(3);
    chk_obs("t3_tanh", 2, 127, -127, 0, 0);
    step(1, 1, 2, 0, 0, 1); obs_clear();
    step(0, 0, 0, 1, 7, 1);
    step(0, 0, 0, 1, -2, 1);
    idle(3);
    chk_obs("t3_relu6", 2, 6, 0, 0, 0);

    // 4. gelu with a relu6 command held off until IDLE.
    step(1, 4, 2, 0, 0, 1); obs_clear();
    step(1, 1, 2, 1, -8, 1);
    step(1, 1, 2, 1, 8, 1);
    step(1, 1, 2, 0, 0, 1);
    step(1, 1, 2, 0, 0, 1);
    step(1, 1, 2, 0, 0, 1);
    step(0, 0, 0, 1, 7, 1);
    step(0, 0, 0, 1, -2, 1);
    idle(3);
    chk("t4_count", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("t4_gelu0", obs_q[0], 0); chk("t4_gelu1", obs_q[1], 4);
      chk("t4_relu6_0", obs_q[2], 6); chk("t4_relu6_1", obs_q[3], 0);
    end
    chk("t4_last_count", obs_last_cnt, 2);

    // 5. zero-length command.
    d0 = done_cnt; v0 = outv_cnt;
    step(1, 0, 0, 1, 5, 1);
    step(0, 0, 0, 1, 5, 1);
    step(0, 0, 0, 1, 5, 1);
    chk("t5_done_pulses", done_cnt - d0, 1);
    chk("t5_no_out_valid", outv_cnt - v0, 0);

    // 6. reset mid-burst, then a fresh burst.
    step(1, 0, 4, 0, 0, 1);
    step(0, 0, 0, 1, 9, 1);
    step(0, 0, 0, 1, 10, 0);
    rst_n = 0;
    #1;
    chk_reset_outputs("t6_midreset");
    model_reset();
    d0 = done_cnt;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    idle(2);
    chk("t6_no_done", done_cnt - d0, 0);
    step(1, 1, 3, 0, 0, 1); obs_clear();
    step(0, 0, 0, 1, 3, 1);
    step(0, 0, 0, 1, 100, 1);
    step(0, 0, 0, 1, -1, 1);
    idle(3);
    chk_obs("t6_after", 3, 3, 6, 0, 0);

    // Maximum burst length: counters must not wrap before the last element.
    step(1, 2, 255, 0, 0, 1); obs_clear();
    guard = 0;
    while ((m_active || m_fin) && guard < 2000) begin
      step(0, 0, 0, $urandom_range(0, 3) != 0, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 3) != 0);
      guard++;
    end
    chk("max_len_timeout", int'(guard >= 2000), 0);
    chk("max_len_count", obs_q.size(), 255);
    chk("max_len_last_count", obs_last_cnt, 1);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) == 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
           $urandom_range(0, 2) != 0, int'($urandom_range(0, 255)) - 128,
           $urandom_range(0, 3) != 0);
    idle(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
